// File: rtl/i2c_master_driver.sv
// i2c_master_driver: single-byte I2C master issuing START, {addr,rw}, one data byte, STOP.
// SCL is push-pull; SDA is open-drain through sda_oe.
module i2c_master_driver #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       busy,
    output logic       scl,
    output logic       sda_oe,
    input  logic       sda_in
);
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] START    = 4'd1;
    localparam logic [3:0] ADDR     = 4'd2;
    localparam logic [3:0] ADDR_ACK = 4'd3;
    localparam logic [3:0] WRITE    = 4'd4;
    localparam logic [3:0] WR_ACK   = 4'd5;
    localparam logic [3:0] READ     = 4'd6;
    localparam logic [3:0] M_NACK   = 4'd7;
    localparam logic [3:0] STOP     = 4'd8;

    logic [3:0]    state, nxt;
    logic [DW-1:0] div;
    logic [1:0]    phase;
    logic [2:0]    bit_cnt;
    logic [7:0]    tx_sh, wdata, rx_sh;
    logic          rw, nack;
    logic          tick, bit_end, sample, last_bit;

    assign tick     = (state != IDLE) && (div == DW'(CLK_DIV - 1));
    assign bit_end  = tick && (phase == 2'd3);
    assign sample   = tick && (phase == 2'd2);
    assign last_bit = (bit_cnt == 3'd7);

    // START/STOP are the only places SDA moves while SCL is high
    always_comb begin
        scl = (state == IDLE) ? 1'b1
            : (state == START) ? !phase[1]
            : (state == STOP) ? (phase != 2'd0)
            : (phase == 2'd1 || phase == 2'd2);
        sda_oe = (state == START) ? 1'b1
               : (state == ADDR || state == WRITE) ? !tx_sh[7]
               : (state == STOP) ? !phase[1]
               : 1'b0;
        nxt = (state == START) ? ADDR
            : (state == ADDR) ? (last_bit ? ADDR_ACK : ADDR)
            : (state == ADDR_ACK) ? (nack ? STOP : rw ? READ : WRITE)
            : (state == WRITE) ? (last_bit ? WR_ACK : WRITE)
            : (state == READ) ? (last_bit ? M_NACK : READ)
            : (state == WR_ACK || state == M_NACK) ? STOP
            : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            div       <= '0;
            phase     <= 2'd0;
            bit_cnt   <= 3'd0;
            tx_sh     <= 8'd0;
            wdata     <= 8'd0;
            rx_sh     <= 8'd0;
            rw        <= 1'b0;
            nack      <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'd0;
            rsp_nack  <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            div <= (state == IDLE || tick) ? '0 : div + 1'b1;
            if (tick) phase <= phase + 2'd1;
            if (rsp_valid) begin
                busy      <= 1'b0;
                cmd_ready <= 1'b1;
            end
            if (cmd_valid && cmd_ready) begin
                tx_sh     <= {cmd_addr, cmd_rw};
                wdata     <= cmd_wdata;
                rw        <= cmd_rw;
                rx_sh     <= 8'd0;
                nack      <= 1'b0;
                bit_cnt   <= 3'd0;
                phase     <= 2'd0;
                cmd_ready <= 1'b0;
                busy      <= 1'b1;
                state     <= START;
            end
            if (sample && (state == ADDR_ACK || state == WR_ACK)) nack <= sda_in;
            if (sample && state == READ) rx_sh <= {rx_sh[6:0], sda_in};
            if (bit_end) begin
                state <= nxt;
                if (state == ADDR || state == WRITE || state == READ) bit_cnt <= bit_cnt + 3'd1;
                // the address shifter is reloaded with the data byte as the last address bit ends
                if (state == ADDR || state == WRITE)
                    tx_sh <= (state == ADDR && last_bit) ? wdata : {tx_sh[6:0], 1'b0};
                if (state == STOP) begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= rx_sh;
                    rsp_nack  <= nack;
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_master_driver.sv
// tb_i2c_master_driver: directed table plus randomized transactions against a bus-level slave model.
module tb_i2c_master_driver;
    localparam int CLK_DIV = 4;

    logic       clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, cmd_rw = 1'b0;
    logic [6:0] cmd_addr = 7'd0;
    logic [7:0] cmd_wdata = 8'd0;
    logic       cmd_ready, rsp_valid, rsp_nack, busy, scl, sda_oe, sda_in;
    logic [7:0] rsp_rdata;

    always #5 clk = ~clk;

    i2c_master_driver #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_rw(cmd_rw), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack),
        .busy(busy), .scl(scl), .sda_oe(sda_oe), .sda_in(sda_in)
    );

    typedef struct {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] wdata;
        logic [6:0] sl_addr;
        logic       ack_d;
        logic [7:0] sl_data;
        logic       exp_nack;
        logic [7:0] exp_rd;
        int         exp_ticks;
    } rec_t;

    int checks = 0, errors = 0;
    int exp_starts = 0, exp_stops = 0, exp_pulses = 0;

    // slave configuration and bus-level slave/monitor state
    logic [6:0] sl_addr = 7'h7F;
    logic       sl_ack_d = 1'b1;
    logic [7:0] sl_data = 8'd0;
    logic       sl_act = 1'b0;
    int         nf = 0;
    logic [7:0] sl_ab = 8'd0;
    logic       sl_pull, acked;
    logic       p_scl = 1'b1, p_oe = 1'b0, rv = 1'b0;
    int         cyc = 0, rise_t = 0;
    int         starts = 0, stops = 0, mon_chk = 0, mon_err = 0;
    logic       stream[$];
    logic       exp_bits[$];
    logic       m_nack;
    logic [7:0] m_rd;
    int         m_ticks;

    // nf counts SCL falls since START, so the current bit index is nf-1
    assign acked = (sl_ab[7:1] == sl_addr);
    always_comb begin
        sl_pull = 1'b0;
        if (sl_act && nf == 9) sl_pull = acked;
        if (sl_act && nf >= 10 && nf <= 17 && acked && sl_ab[0]) sl_pull = !sl_data[17 - nf];
        if (sl_act && nf == 18 && acked && !sl_ab[0]) sl_pull = sl_ack_d;
    end
    assign sda_in = !sda_oe && !sl_pull;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            p_scl <= 1'b1;
            p_oe  <= 1'b0;
            rv    <= 1'b0;
        end else begin
            p_scl <= scl;
            p_oe  <= sda_oe;
            if (p_scl && scl && p_oe != sda_oe) begin
                if (sda_oe) begin
                    starts <= starts + 1;
                    sl_act <= 1'b1;
                    nf     <= 0;
                    rv     <= 1'b0;
                    stream.delete();
                end else begin
                    stops  <= stops + 1;
                    sl_act <= 1'b0;
                end
            end
            if (!p_scl && scl) begin
                rise_t <= cyc;
                rv     <= 1'b1;
                if (sl_act) begin
                    stream.push_back(sda_in);
                    if (nf >= 1 && nf <= 8) sl_ab <= {sl_ab[6:0], sda_in};
                end
            end
            if (p_scl && !scl) begin
                if (sl_act) nf <= nf + 1;
                if (rv) begin
                    mon_chk <= mon_chk + 1;
                    if (cyc - rise_t != 2 * CLK_DIV) begin
                        mon_err <= mon_err + 1;
                        $display("FAIL scl_high_width: got %0d cycles, expected %0d", cyc - rise_t, 2 * CLK_DIV);
                    end
                end
                rv <= 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic q[$]);
        logic [31:0] v = 32'd0;
        foreach (q[i]) v = {v[30:0], q[i]};
        return v;
    endfunction

    // Bus-level expectation: bits seen on each SCL rise, plus the STOP rise with SDA low
    function automatic void model(input rec_t r);
        logic [7:0] ab;
        logic       aack;
        ab   = {r.addr, r.rw};
        aack = (r.addr == r.sl_addr);
        exp_bits.delete();
        for (int i = 7; i >= 0; i--) exp_bits.push_back(ab[i]);
        exp_bits.push_back(!aack);
        if (aack) begin
            for (int i = 7; i >= 0; i--) exp_bits.push_back(r.rw ? r.sl_data[i] : r.wdata[i]);
            exp_bits.push_back(r.rw ? 1'b1 : !r.ack_d);
        end
        exp_bits.push_back(1'b0);
        m_nack  = !aack || (!r.rw && !r.ack_d);
        m_rd    = r.sl_data;
        m_ticks = aack ? 80 : 44;
    endfunction

    task automatic do_txn(input rec_t r, input logic keep);
        int   n, w;
        logic bad;
        sl_addr   = r.sl_addr;
        sl_ack_d  = r.ack_d;
        sl_data   = r.sl_data;
        cmd_addr  = r.addr;
        cmd_rw    = r.rw;
        cmd_wdata = r.wdata;
        cmd_valid = 1'b1;
        model(r);
        w = 0;
        while (cmd_ready !== 1'b1 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 1000) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: got cmd_ready=%0b expected 1", cmd_ready);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        n = 0;
        bad = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (busy !== 1'b1 || cmd_ready !== 1'b0) bad = 1'b1;
            if (!keep) begin
                cmd_valid = ($urandom_range(0, 3) == 0);
                cmd_addr  = 7'($urandom);
                cmd_rw    = 1'($urandom);
                cmd_wdata = 8'($urandom);
            end
        end while (rsp_valid !== 1'b1 && n < 2000);
        if (!keep) cmd_valid = 1'b0;
        chk("latency", n, r.exp_ticks * CLK_DIV + 1);
        chk("busy_window", bad, 0);
        chk("rsp_nack", rsp_nack, r.exp_nack);
        if (r.rw && !r.exp_nack) chk("rsp_rdata", rsp_rdata, r.exp_rd);
        chk("stream_len", stream.size(), exp_bits.size());
        chk("stream_bits", pack(stream), pack(exp_bits));
        exp_starts++;
        exp_stops++;
        exp_pulses += exp_bits.size() - 1;
    endtask

    initial begin
        rec_t tbl[7];
        rec_t r;
        logic seen;
        tbl[0] = '{7'h7F, 1'b0, 8'hA5, 7'h7F, 1'b1, 8'h00, 1'b0, 8'h00, 80};
        tbl[1] = '{7'h78, 1'b1, 8'h00, 7'h78, 1'b1, 8'h3C, 1'b0, 8'h3C, 80};
        tbl[2] = '{7'h12, 1'b0, 8'h00, 7'h7F, 1'b1, 8'h00, 1'b1, 8'h00, 44};
        tbl[3] = '{7'h7F, 1'b0, 8'h3C, 7'h7F, 1'b0, 8'h00, 1'b1, 8'h00, 80};
        tbl[4] = '{7'h00, 1'b1, 8'h00, 7'h00, 1'b1, 8'h00, 1'b0, 8'h00, 80};
        tbl[5] = '{7'h55, 1'b1, 8'h00, 7'h55, 1'b1, 8'hFF, 1'b0, 8'hFF, 80};
        tbl[6] = '{7'h12, 1'b1, 8'h00, 7'h7F, 1'b1, 8'hAA, 1'b1, 8'h00, 44};

        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_nack", rsp_nack, 0);
        chk("rst_scl", scl, 1);
        chk("rst_sda_oe", sda_oe, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_scl", scl, 1);

        foreach (tbl[i]) begin
            repeat (2) @(negedge clk);
            do_txn(tbl[i], 1'b0);
        end

        // back-to-back commands with cmd_valid held high
        repeat (3) @(negedge clk);
        do_txn(tbl[0], 1'b1);
        @(negedge clk);
        chk("b2b_gap_busy", busy, 0);
        chk("b2b_gap_ready", cmd_ready, 1);
        do_txn(tbl[0], 1'b0);

        // reset during bit 3 of the data byte (0x5A keeps SDA released on that bit)
        repeat (3) @(negedge clk);
        r = '{7'h7F, 1'b0, 8'h5A, 7'h7F, 1'b1, 8'h00, 1'b0, 8'h00, 80};
        sl_addr = r.sl_addr;
        sl_ack_d = 1'b1;
        cmd_addr = r.addr;
        cmd_rw = r.rw;
        cmd_wdata = r.wdata;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (209) @(negedge clk);
        chk("busy_before_rst", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_scl", scl, 1);
        chk("midrst_sda_oe", sda_oe, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_cmd_ready", cmd_ready, 1);
        seen = rsp_valid;
        repeat (400) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("midrst_no_rsp", seen, 0);
        exp_starts++;
        exp_pulses += 12;

        for (int i = 0; i < 16; i++) begin
            r.addr    = 7'($urandom);
            r.rw      = 1'($urandom);
            r.wdata   = 8'($urandom);
            r.sl_addr = ($urandom_range(0, 3) == 0) ? r.addr + 7'd1 : r.addr;
            r.ack_d   = ($urandom_range(0, 3) != 0);
            r.sl_data = 8'($urandom);
            model(r);
            r.exp_nack  = m_nack;
            r.exp_rd    = m_rd;
            r.exp_ticks = m_ticks;
            repeat ($urandom_range(0, 5)) @(negedge clk);
            do_txn(r, 1'b0);
        end

        repeat (5) @(negedge clk);
        chk("start_count", starts, exp_starts);
        chk("stop_count", stops, exp_stops);
        chk("scl_pulse_count", mon_chk, exp_pulses);
        chk("scl_pulse_width_errors", mon_err, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
